// File: rtl/launch_angle_solver.sv
// Inverse projectile solver: sweeps launch angles 0..45 deg and reports the
// angle whose fixed-point range (sin/cos x1000, gravity x100) lands nearest the target.
module launch_angle_solver #(
   parameter int ANGLE_STEP     = 5,
   parameter int NUM_CANDIDATES = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] initialVelocity,
   input  logic [15:0] targetRange,
   input  logic [15:0] customGravity,
   input  logic [15:0] tolerance,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic        error,
   output logic [15:0] launchAngle,
   output logic [15:0] achievedRange
);

   typedef enum logic [2:0] {IDLE, LOOKUP, CALC, COMPARE, DONE} state_t;

   state_t state, next_state;

   logic [15:0] vel_q, target_q, grav_q, tol_q;
   logic [7:0]  idx;
   logic [9:0]  sin_k, cos_k;
   logic [15:0] range_k;
   logic [16:0] best_err;
   logic [15:0] best_angle, best_range;

   logic [15:0] cand_angle;
   logic [9:0]  sin_lut_val, cos_lut_val;
   logic [20:0] twice_sc;
   logic [31:0] vel_sq;
   logic [63:0] num, quot;
   logic [39:0] den;
   logic [15:0] range_calc;
   logic [16:0] err_calc, final_err;
   logic [15:0] final_angle, final_range;
   logic        better, is_last;

   // Sine in 5-degree steps over 0..90, scaled by 1000; cosine reuses it via 90-angle
   function automatic logic [9:0] sin_lut(input logic [15:0] deg);
      case (deg)
         16'd0:   sin_lut = 10'd0;
         16'd5:   sin_lut = 10'd87;
         16'd10:  sin_lut = 10'd174;
         16'd15:  sin_lut = 10'd259;
         16'd20:  sin_lut = 10'd342;
         16'd25:  sin_lut = 10'd423;
         16'd30:  sin_lut = 10'd500;
         16'd35:  sin_lut = 10'd574;
         16'd40:  sin_lut = 10'd643;
         16'd45:  sin_lut = 10'd707;
         16'd50:  sin_lut = 10'd766;
         16'd55:  sin_lut = 10'd819;
         16'd60:  sin_lut = 10'd866;
         16'd65:  sin_lut = 10'd906;
         16'd70:  sin_lut = 10'd940;
         16'd75:  sin_lut = 10'd966;
         16'd80:  sin_lut = 10'd985;
         16'd85:  sin_lut = 10'd996;
         16'd90:  sin_lut = 10'd1000;
         default: sin_lut = 10'd0;
      endcase
   endfunction

   assign cand_angle  = 16'(idx) * 16'(ANGLE_STEP);
   assign sin_lut_val = sin_lut(cand_angle);
   assign cos_lut_val = (cand_angle <= 16'd90) ? sin_lut(16'd90 - cand_angle) : 10'd0;

   // Range = v^2 * sin(2a) / g with the x1000 and x100 scale factors folded into den
   assign twice_sc   = 21'd2 * 21'(sin_k) * 21'(cos_k);
   assign vel_sq     = 32'(vel_q) * 32'(vel_q);
   assign num        = 64'(vel_sq) * 64'(twice_sc);
   assign den        = 40'(grav_q) * 40'd10000;
   assign quot       = num / 64'(den);
   assign range_calc = (quot > 64'h0000_0000_0000_FFFF) ? 16'hFFFF : quot[15:0];

   assign err_calc    = (range_k >= target_q) ? 17'(range_k - target_q) : 17'(target_q - range_k);
   assign better      = err_calc < best_err;
   assign final_err   = better ? err_calc   : best_err;
   assign final_angle = better ? cand_angle : best_angle;
   assign final_range = better ? range_k    : best_range;
   assign is_last     = (idx == 8'(NUM_CANDIDATES - 1));

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Zero gravity is detected one cycle after capture so the check sees the registered value
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOOKUP;
         LOOKUP:  next_state = (grav_q == 16'd0) ? DONE : CALC;
         CALC:    next_state = COMPARE;
         COMPARE: next_state = is_last ? DONE : LOOKUP;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vel_q         <= '0;
         target_q      <= '0;
         grav_q        <= '0;
         tol_q         <= '0;
         idx           <= '0;
         sin_k         <= '0;
         cos_k         <= '0;
         range_k       <= '0;
         best_err      <= 17'h1FFFF;
         best_angle    <= '0;
         best_range    <= '0;
         found         <= 1'b0;
         error         <= 1'b0;
         launchAngle   <= '0;
         achievedRange <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  vel_q      <= initialVelocity;
                  target_q   <= targetRange;
                  grav_q     <= customGravity;
                  tol_q      <= tolerance;
                  idx        <= '0;
                  best_err   <= 17'h1FFFF;
                  best_angle <= '0;
                  best_range <= '0;
               end
            end
            LOOKUP: begin
               sin_k <= sin_lut_val;
               cos_k <= cos_lut_val;
               if (grav_q == 16'd0) begin
                  error         <= 1'b1;
                  found         <= 1'b0;
                  launchAngle   <= '0;
                  achievedRange <= '0;
               end
            end
            CALC: range_k <= range_calc;
            COMPARE: begin
               best_err   <= final_err;
               best_angle <= final_angle;
               best_range <= final_range;
               if (is_last) begin
                  launchAngle   <= final_angle;
                  achievedRange <= final_range;
                  found         <= (final_err <= {1'b0, tol_q});
                  error         <= 1'b0;
               end else begin
                  idx <= idx + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
